sd_request_arbiter: RTL and testbench

Shares one `sd_card_controller` between `N_REQ` requesters, such as a file-system reader and a logging writer, at single-sector granularity. It grants one requester at a time in round-robin order and drives the controller's op/execute/sector inputs. It routes the 512-byte stream between the controller and the granted requester, and checks each transfer for byte-count and timeout errors. It sits directly above `sd_card_controller` and below all SD clients.

---
 rtl/sd_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/sd_request_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_sd_request_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// Shared definitions for the SD request arbiter: op codes, FSM encoding and sector geometry.
package sd_pkg;

  localparam logic SD_OP_READ  = 1'b0;
  localparam logic SD_OP_WRITE = 1'b1;

  localparam int unsigned SD_SECTOR_ADDR_W = 26;
  localparam int unsigned SD_SECTOR_BYTES  = 512;

  localparam int unsigned SD_STATE_W = 3;
  localparam logic [SD_STATE_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [SD_STATE_W-1:0] ST_ISSUE     = 3'd1;
  localparam logic [SD_STATE_W-1:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [SD_STATE_W-1:0] ST_XFER      = 3'd3;
  localparam logic [SD_STATE_W-1:0] ST_FINISH    = 3'd4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping around.
module rr_arbiter #(
  parameter int unsigned N = 2,
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt_onehot,
  output logic [IDX_W-1:0] gnt_idx
);

  logic             w_found;
  logic [IDX_W-1:0] w_idx;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    w_found    = 1'b0;
    w_idx      = '0;
    for (int i = 0; i < N; i++) begin
      w_idx = IDX_W'((int'(ptr) + i) % N);
      if (!w_found && req[w_idx]) begin
        w_found           = 1'b1;
        gnt_idx           = w_idx;
        gnt_onehot[w_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sd_request_arbiter.sv
// Shares one sd_card_controller between N_REQ requesters, one sector per grant,
// routing the byte stream to the owner and flagging byte-count and timeout errors.
module sd_request_arbiter
  import sd_pkg::*;
#(
  parameter int unsigned N_REQ          = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned SECTOR_BYTES   = SD_SECTOR_BYTES
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [N_REQ-1:0]                  req_valid,
  input  logic [N_REQ-1:0]                  req_op,
  input  logic [N_REQ*SD_SECTOR_ADDR_W-1:0] req_sector,
  input  logic [N_REQ*8-1:0]                wr_data,
  output logic [N_REQ-1:0]                  grant,
  output logic [N_REQ-1:0]                  wr_ack,
  output logic [7:0]                        rd_data,
  output logic [N_REQ-1:0]                  rd_valid,
  output logic [N_REQ-1:0]                  done,
  output logic [N_REQ-1:0]                  err,
  output logic                              sd_op_code,
  output logic                              sd_execute,
  output logic [SD_SECTOR_ADDR_W-1:0]       sd_sector_address,
  output logic [7:0]                        sd_outgoing_byte,
  input  logic [7:0]                        sd_incoming_byte,
  input  logic                              sd_finished_byte,
  input  logic                              sd_finished_sector,
  input  logic                              sd_busy
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = 10;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] SECTOR_CNT = CNT_W'(SECTOR_BYTES);
  localparam logic [TMO_W-1:0] TMO_LIMIT  = TMO_W'(TIMEOUT_CYCLES);

  logic [SD_STATE_W-1:0] r_state, w_state_nxt;
  logic [IDX_W-1:0]      r_owner, w_owner_nxt;
  logic [IDX_W-1:0]      r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0]      r_count, w_count_nxt;
  logic [TMO_W-1:0]      r_tmo, w_tmo_nxt;
  logic                  r_fail, w_fail_nxt;
  logic                  r_byte_prev, r_sector_prev;

  logic [N_REQ-1:0]            w_grant_nxt, w_wr_ack_nxt, w_rd_valid_nxt, w_done_nxt, w_err_nxt;
  logic                        w_exec_nxt, w_op_nxt;
  logic [SD_SECTOR_ADDR_W-1:0] w_sector_nxt, w_sector_sel;
  logic [7:0]                  w_rd_data_nxt, w_wr_byte;
  logic [N_REQ-1:0]            w_gnt_onehot, w_owner_mask;
  logic [IDX_W-1:0]            w_gnt_idx;
  logic                        w_byte_edge, w_sector_edge, w_tmo_hit;
  logic [CNT_W-1:0]            w_cnt_inc;
  logic [TMO_W-1:0]            w_tmo_inc;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req        (req_valid),
    .ptr        (r_ptr),
    .gnt_onehot (w_gnt_onehot),
    .gnt_idx    (w_gnt_idx)
  );

  // Per-requester slice selection for the candidate sector and the owner's write byte
  always_comb begin
    w_sector_sel = '0;
    w_wr_byte    = '0;
    w_owner_mask = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt_idx == IDX_W'(i)) w_sector_sel = req_sector[i*SD_SECTOR_ADDR_W +: SD_SECTOR_ADDR_W];
      if (r_owner == IDX_W'(i)) begin
        w_wr_byte       = wr_data[i*8 +: 8];
        w_owner_mask[i] = 1'b1;
      end
    end
  end

  assign w_byte_edge   = sd_finished_byte & ~r_byte_prev;
  assign w_sector_edge = sd_finished_sector & ~r_sector_prev;
  assign w_cnt_inc     = CNT_W'(r_count + 1'b1);
  assign w_tmo_inc     = TMO_W'(r_tmo + 1'b1);
  assign w_tmo_hit     = (w_tmo_inc >= TMO_LIMIT);

  assign sd_outgoing_byte = (r_state == ST_XFER && sd_op_code == SD_OP_WRITE) ? w_wr_byte : 8'hFF;

  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_ptr_nxt      = r_ptr;
    w_count_nxt    = r_count;
    w_tmo_nxt      = r_tmo;
    w_fail_nxt     = r_fail;
    w_grant_nxt    = grant;
    w_op_nxt       = sd_op_code;
    w_sector_nxt   = sd_sector_address;
    w_rd_data_nxt  = rd_data;
    w_exec_nxt     = 1'b0;
    w_wr_ack_nxt   = '0;
    w_rd_valid_nxt = '0;
    w_done_nxt     = '0;
    w_err_nxt      = '0;
    case (r_state)
      ST_IDLE: begin
        if (|req_valid) begin
          w_state_nxt  = ST_ISSUE;
          w_owner_nxt  = w_gnt_idx;
          w_grant_nxt  = w_gnt_onehot;
          w_op_nxt     = req_op[w_gnt_idx];
          w_sector_nxt = w_sector_sel;
        end
      end
      ST_ISSUE: begin
        w_exec_nxt  = 1'b1;
        w_count_nxt = '0;
        w_tmo_nxt   = '0;
        w_fail_nxt  = 1'b0;
        w_state_nxt = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (sd_busy) begin
          w_state_nxt = ST_XFER;
          w_tmo_nxt   = '0;
        end else if (w_tmo_hit) begin
          w_state_nxt = ST_FINISH;
          w_fail_nxt  = 1'b1;
        end else begin
          w_tmo_nxt = w_tmo_inc;
        end
      end
      ST_XFER: begin
        // A byte edge is counted before a coincident sector edge is judged
        if (w_byte_edge) begin
          w_tmo_nxt = '0;
          if (r_count == SECTOR_CNT) begin
            w_fail_nxt  = 1'b1;
            w_state_nxt = ST_FINISH;
          end else begin
            w_count_nxt = w_cnt_inc;
            if (sd_op_code == SD_OP_WRITE) begin
              w_wr_ack_nxt = w_owner_mask;
            end else begin
              w_rd_valid_nxt = w_owner_mask;
              w_rd_data_nxt  = sd_incoming_byte;
            end
            if (w_sector_edge) begin
              w_state_nxt = ST_FINISH;
              w_fail_nxt  = (w_cnt_inc != SECTOR_CNT);
            end
          end
        end else if (w_sector_edge) begin
          w_tmo_nxt   = '0;
          w_state_nxt = ST_FINISH;
          w_fail_nxt  = (r_count != SECTOR_CNT);
        end else if (w_tmo_hit) begin
          w_state_nxt = ST_FINISH;
          w_fail_nxt  = 1'b1;
        end else begin
          w_tmo_nxt = w_tmo_inc;
        end
      end
      ST_FINISH: begin
        if (r_fail) w_err_nxt = w_owner_mask;
        else        w_done_nxt = w_owner_mask;
        w_ptr_nxt    = (r_owner == IDX_W'(N_REQ - 1)) ? '0 : IDX_W'(r_owner + 1'b1);
        w_grant_nxt  = '0;
        w_op_nxt     = 1'b0;
        w_sector_nxt = '0;
        w_state_nxt  = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state           <= ST_IDLE;
      r_owner           <= '0;
      r_ptr             <= '0;
      r_count           <= '0;
      r_tmo             <= '0;
      r_fail            <= 1'b0;
      r_byte_prev       <= 1'b0;
      r_sector_prev     <= 1'b0;
      grant             <= '0;
      wr_ack            <= '0;
      rd_valid          <= '0;
      done              <= '0;
      err               <= '0;
      rd_data           <= '0;
      sd_execute        <= 1'b0;
      sd_op_code        <= 1'b0;
      sd_sector_address <= '0;
    end else begin
      r_state           <= w_state_nxt;
      r_owner           <= w_owner_nxt;
      r_ptr             <= w_ptr_nxt;
      r_count           <= w_count_nxt;
      r_tmo             <= w_tmo_nxt;
      r_fail            <= w_fail_nxt;
      r_byte_prev       <= sd_finished_byte;
      r_sector_prev     <= sd_finished_sector;
      grant             <= w_grant_nxt;
      wr_ack            <= w_wr_ack_nxt;
      rd_valid          <= w_rd_valid_nxt;
      done              <= w_done_nxt;
      err               <= w_err_nxt;
      rd_data           <= w_rd_data_nxt;
      sd_execute        <= w_exec_nxt;
      sd_op_code        <= w_op_nxt;
      sd_sector_address <= w_sector_nxt;
    end
  end

endmodule

// File: tb/tb_sd_request_arbiter.sv
// Bench for sd_request_arbiter: negedge-driven controller model, table of single-sector
// transfers, then round-robin, timeout and mid-transfer reset sequences.
module tb_sd_request_arbiter;
  import sd_pkg::*;

  localparam logic [63:0] RST_EXP = 64'h00000000000000FF;

  logic        clk, rst_n;
  logic [1:0]  req_valid, req_op;
  logic [51:0] req_sector;
  logic [15:0] wr_data;
  logic [1:0]  grant, wr_ack, rd_valid, done, err;
  logic [7:0]  rd_data, sd_outgoing_byte, sd_incoming_byte;
  logic        sd_op_code, sd_execute, sd_finished_byte, sd_finished_sector, sd_busy;
  logic [25:0] sd_sector_address;

  sd_request_arbiter #(.N_REQ(2), .TIMEOUT_CYCLES(50), .SECTOR_BYTES(512)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
    .req_sector(req_sector), .wr_data(wr_data), .grant(grant), .wr_ack(wr_ack),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
    .sd_op_code(sd_op_code), .sd_execute(sd_execute), .sd_sector_address(sd_sector_address),
    .sd_outgoing_byte(sd_outgoing_byte), .sd_incoming_byte(sd_incoming_byte),
    .sd_finished_byte(sd_finished_byte), .sd_finished_sector(sd_finished_sector),
    .sd_busy(sd_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] rd_pat(input int k);
    return 8'((k * 37 + 5) % 256);
  endfunction

  // Controller model configuration (written by the main sequence only)
  int m_nbytes;
  bit m_coin, m_no_busy;
  bit m_active = 1'b0;
  int m_wr_bad = 0;

  task automatic run_sector();
    m_active = 1'b1;
    @(negedge clk);
    if (rst_n) sd_busy = 1'b1;
    @(negedge clk);
    for (int k = 0; k < m_nbytes; k++) begin
      if (!rst_n) break;
      sd_incoming_byte = rd_pat(k);
      if (sd_op_code == SD_OP_WRITE && sd_outgoing_byte != 8'(k)) m_wr_bad++;
      sd_finished_byte = 1'b1;
      if (m_coin && k == m_nbytes - 1) sd_finished_sector = 1'b1;
      @(negedge clk);
      if (k % 3 == 0) @(negedge clk);
      sd_finished_byte = 1'b0;
      @(negedge clk);
    end
    if (rst_n && !m_coin) begin
      sd_finished_sector = 1'b1;
      @(negedge clk);
    end
    sd_finished_sector = 1'b0;
    sd_finished_byte   = 1'b0;
    sd_busy            = 1'b0;
    m_active           = 1'b0;
  endtask

  initial begin
    sd_busy = 1'b0; sd_finished_byte = 1'b0; sd_finished_sector = 1'b0; sd_incoming_byte = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n && sd_execute && !m_no_busy) run_sector();
    end
  end

  // Write sources: per-requester byte counters advanced by wr_ack
  logic [7:0] wr_cnt0, wr_cnt1;
  assign wr_data = {wr_cnt1, wr_cnt0};
  initial begin
    wr_cnt0 = 8'h00; wr_cnt1 = 8'h00;
    forever begin
      @(negedge clk);
      if (sd_execute) begin
        wr_cnt0 = 8'h00; wr_cnt1 = 8'h00;
      end else begin
        if (wr_ack[0]) wr_cnt0 = wr_cnt0 + 8'd1;
        if (wr_ack[1]) wr_cnt1 = wr_cnt1 + 8'd1;
      end
    end
  end

  // Output monitor
  int n_rdv[2], n_wack[2], n_done[2], n_err[2];
  int n_exec = 0, n_rd_bad = 0, rd_idx = 0, gl_n = 0;
  int glog[32];
  logic [25:0] exec_sec = '0;
  logic [1:0]  prev_g = '0;
  initial begin
    for (int i = 0; i < 2; i++) begin n_rdv[i] = 0; n_wack[i] = 0; n_done[i] = 0; n_err[i] = 0; end
    forever begin
      @(negedge clk);
      if (sd_execute) begin n_exec++; exec_sec = sd_sector_address; rd_idx = 0; end
      if (rd_valid != 2'b00) begin
        if (rd_data != rd_pat(rd_idx)) n_rd_bad++;
        rd_idx++;
      end
      for (int i = 0; i < 2; i++) begin
        if (rd_valid[i]) n_rdv[i]++;
        if (wr_ack[i])   n_wack[i]++;
        if (done[i])     n_done[i]++;
        if (err[i])      n_err[i]++;
      end
      if (prev_g == 2'b00 && grant != 2'b00 && gl_n < 32) begin
        glog[gl_n] = (grant == 2'b10) ? 1 : 0;
        gl_n++;
      end
      prev_g = grant;
    end
  end

  int tests = 0, fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({grant, wr_ack, rd_valid, done, err, sd_execute, sd_op_code,
                sd_sector_address, rd_data, sd_outgoing_byte});
  endfunction

  task automatic settle();
    repeat (3) @(negedge clk);
    #1;
  endtask

  task automatic wait_model();
    int n = 0;
    while (m_active && n < 300) begin @(negedge clk); n++; end
    check("model_idle", 64'(m_active), 64'd0);
  endtask

  typedef struct {
    string       name;
    logic [1:0]  rv;
    logic [1:0]  op;
    logic [25:0] sec0;
    int          nb;
    bit          coin;
    int          exp_own;
    logic [25:0] exp_sec;
    int          exp_pulses;
    bit          exp_ok;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int b_rd, b_wk, b_ex, b_rbad, b_wbad, n;
    logic [1:0] d_seen, e_seen, own_oh;
    own_oh = 2'(1 << v.exp_own);
    settle();
    b_rd = n_rdv[v.exp_own]; b_wk = n_wack[v.exp_own]; b_ex = n_exec;
    b_rbad = n_rd_bad; b_wbad = m_wr_bad;
    req_op = v.op; req_sector = {v.sec0 + 26'd1, v.sec0};
    m_nbytes = v.nb; m_coin = v.coin; req_valid = v.rv;
    n = 0;
    while (grant == 2'b00 && n < 20) begin @(negedge clk); n++; end
    check({v.name, "_grant"}, 64'(grant), 64'(own_oh));
    req_valid = 2'b00;
    d_seen = '0; e_seen = '0; n = 0;
    while (d_seen == 2'b00 && e_seen == 2'b00 && n < 6000) begin
      @(negedge clk); d_seen = done; e_seen = err; n++;
    end
    check({v.name, "_done"}, 64'(d_seen), v.exp_ok ? 64'(own_oh) : 64'd0);
    check({v.name, "_err"}, 64'(e_seen), v.exp_ok ? 64'd0 : 64'(own_oh));
    check({v.name, "_grant_clear"}, 64'(grant), 64'd0);
    wait_model();
    settle();
    if (v.op[v.exp_own]) check({v.name, "_wr_acks"}, 64'(n_wack[v.exp_own] - b_wk), 64'(v.exp_pulses));
    else                 check({v.name, "_rd_valids"}, 64'(n_rdv[v.exp_own] - b_rd), 64'(v.exp_pulses));
    check({v.name, "_exec_count"}, 64'(n_exec - b_ex), 64'd1);
    check({v.name, "_exec_sector"}, 64'(exec_sec), 64'(v.exp_sec));
    check({v.name, "_rd_bytes"}, 64'(n_rd_bad - b_rbad), 64'd0);
    check({v.name, "_wr_bytes"}, 64'(m_wr_bad - b_wbad), 64'd0);
  endtask

  vec_t vecs[6];

  initial begin
    int k, n, t0, t1, b0, b1, bd, be, gl0;
    logic [1:0] e_seen, d_any;
    rst_n = 1'b0; req_valid = '0; req_op = '0; req_sector = '0;
    m_nbytes = 512; m_coin = 1'b0; m_no_busy = 1'b0;

    vecs[0] = '{"single_read",   2'b01, 2'b00, 26'h0012345, 512, 1'b0, 0, 26'h0012345, 512, 1'b1};
    vecs[1] = '{"write_stream",  2'b10, 2'b10, 26'h0000006, 512, 1'b0, 1, 26'h0000007, 512, 1'b1};
    vecs[2] = '{"short_sector",  2'b01, 2'b00, 26'h0000100, 100, 1'b0, 0, 26'h0000100, 100, 1'b0};
    vecs[3] = '{"overflow",      2'b10, 2'b00, 26'h3FFFFFE, 513, 1'b0, 1, 26'h3FFFFFF, 512, 1'b0};
    vecs[4] = '{"coincide_ok",   2'b01, 2'b00, 26'h2AAAAAA, 512, 1'b1, 0, 26'h2AAAAAA, 512, 1'b1};
    vecs[5] = '{"coincide_short",2'b10, 2'b10, 26'h0000055, 511, 1'b1, 1, 26'h0000056, 511, 1'b0};

    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", outs(), RST_EXP);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 6; v++) run_vec(vecs[v]);

    // Round robin with both requesters holding their requests
    settle();
    b0 = n_done[0]; b1 = n_done[1]; gl0 = gl_n;
    req_op = 2'b00; m_nbytes = 512; m_coin = 1'b0;
    req_sector = {26'h0000200, 26'h0000100};
    req_valid = 2'b11;
    k = 0; n = 0;
    while (k < 4 && n < 12000) begin
      @(negedge clk);
      if (done != 2'b00) k++;
      if (k == 4) req_valid = 2'b00;
      n++;
    end
    req_valid = 2'b00;
    wait_model();
    settle();
    check("rr_sectors", 64'(k), 64'd4);
    check("rr_grant_total", 64'(gl_n - gl0), 64'd4);
    for (int i = 0; i < 4; i++) check($sformatf("rr_order_%0d", i), 64'(glog[gl0 + i]), 64'(i % 2));
    check("rr_done0", 64'(n_done[0] - b0), 64'd2);
    check("rr_done1", 64'(n_done[1] - b1), 64'd2);

    // Timeout: controller never goes busy
    m_no_busy = 1'b1;
    req_op = 2'b00;
    req_valid = 2'b01;
    n = 0;
    while (!sd_execute && n < 20) begin @(negedge clk); n++; end
    t0 = cyc;
    req_valid = 2'b00;
    e_seen = '0; d_any = '0; n = 0;
    while (e_seen == 2'b00 && n < 200) begin
      @(negedge clk); e_seen = err; d_any = d_any | done; n++;
    end
    t1 = cyc;
    check("tmo_err", 64'(e_seen), 64'd1);
    check("tmo_latency", 64'(t1 - t0), 64'd51);
    check("tmo_no_done", 64'(d_any), 64'd0);
    check("tmo_grant_clear", 64'(grant), 64'd0);
    m_no_busy = 1'b0;
    settle();

    // Reset in the middle of a read
    bd = n_done[0] + n_done[1]; be = n_err[0] + n_err[1];
    req_op = 2'b00; m_nbytes = 512; m_coin = 1'b0;
    req_valid = 2'b01;
    n = 0;
    while (grant == 2'b00 && n < 20) begin @(negedge clk); n++; end
    req_valid = 2'b00;
    k = 0; n = 0;
    while (k < 200 && n < 3000) begin
      @(negedge clk);
      if (rd_valid[0]) k++;
      n++;
    end
    check("rst_mid_bytes", 64'(k), 64'd200);
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", outs(), RST_EXP);
    repeat (5) @(negedge clk);
    wait_model();
    rst_n = 1'b1;
    settle();
    check("rst_mid_no_done", 64'(n_done[0] + n_done[1] - bd), 64'd0);
    check("rst_mid_no_err", 64'(n_err[0] + n_err[1] - be), 64'd0);
    req_valid = 2'b11;
    n = 0;
    while (grant == 2'b00 && n < 20) begin @(negedge clk); n++; end
    check("rst_next_grant", 64'(grant), 64'd1);
    req_valid = 2'b00;
    d_any = '0; n = 0;
    while (d_any == 2'b00 && n < 6000) begin @(negedge clk); d_any = done; n++; end
    check("rst_next_done", 64'(d_any), 64'd1);
    wait_model();
    settle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
